// File: rtl/snow64_instr_encoder_if.sv
// snow64_instr_encoder_if
//   Request/response bundle for the Snow64 instruction encoder.
//   Request side : in_valid/in_ready handshake plus the decoded fields
//                  (group, op_type, ra, rb, rc, oper, imm).
//   Response side: out_valid/out_ready handshake plus the 32-bit word.
//   slave  modport: the encoder.
//   master modport: the producer of requests and consumer of words.
interface snow64_instr_encoder_if #(
  parameter int WIDTH_IMM = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_group;
  logic                 in_op_type;
  logic [3:0]           in_ra;
  logic [3:0]           in_rb;
  logic [3:0]           in_rc;
  logic [3:0]           in_oper;
  logic [WIDTH_IMM-1:0] in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;

  modport slave (
    input  in_valid, in_group, in_op_type, in_ra, in_rb, in_rc, in_oper,
           in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );

  modport master (
    output in_valid, in_group, in_op_type, in_ra, in_rb, in_rc, in_oper,
           in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/snow64_instr_encoder.sv
// snow64_instr_encoder
//   Packs decoded instruction fields into 32-bit Snow64 instruction words
//   (inverse of the decoder layout), checks group/oper/immediate legality,
//   and queues legal words in a DEPTH-entry FIFO. Illegal requests are still
//   handshaken, but are dropped and flagged on err_valid/err_code.
// Ports
//   clk, rst    clock; synchronous active-high reset
//   bus         snow64_instr_encoder_if.slave (request + response channels)
//   err_valid   1-cycle pulse after a rejected request
//   err_code    1=bad group 2=imm range 3=bad oper; held until next reject
//   count       FIFO occupancy
//   err_count   (only with SNOW64_INSTR_ENCODER_ERR_COUNT_EN) saturating
//               reject counter
// Configuration
//   SNOW64_INSTR_ENCODER_ERR_COUNT_EN  adds err_count[15:0]
module snow64_instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int WIDTH_IMM = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  snow64_instr_encoder_if.slave      bus,
  output logic                       err_valid,
  output logic [1:0]                 err_code,
`ifdef SNOW64_INSTR_ENCODER_ERR_COUNT_EN
  output logic [15:0]                err_count,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] E_GROUP = 2'd1;
  localparam logic [1:0] E_IMM   = 2'd2;
  localparam logic [1:0] E_OPER  = 2'd3;

  typedef struct packed {
    logic [2:0]           group;
    logic                 op_type;
    logic [3:0]           ra;
    logic [3:0]           rb;
    logic [3:0]           rc;
    logic [3:0]           oper;
    logic [WIDTH_IMM-1:0] imm;
  } enc_req_t;

  typedef enum logic {S_EMPTY, S_NONEMPTY} state_t;

  enc_req_t          req;
  state_t            state, state_nxt;
  logic [DEPTH-1:0][31:0] mem;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic [31:0]       word;
  logic              bad_group, bad_oper, bad_imm, legal;
  logic              accept, push, pop;
  logic [1:0]        code;

  assign req = '{group:   bus.in_group,
                 op_type: bus.in_op_type,
                 ra:      bus.in_ra,
                 rb:      bus.in_rb,
                 rc:      bus.in_rc,
                 oper:    bus.in_oper,
                 imm:     bus.in_imm};

  // True when v is the sign-extension of its low w bits: everything from
  // bit w-1 upward must be all zeros or all ones.
  function automatic logic sext_ok(input logic [WIDTH_IMM-1:0] v,
                                   input int unsigned w);
    logic [WIDTH_IMM-1:0] m;
    m = {WIDTH_IMM{1'b1}} << (w - 1);
    return ((v & m) == m) || ((v & m) == '0);
  endfunction

  // ---------------- encode + legality ----------------
  always_comb begin
    word      = '0;
    bad_oper  = 1'b0;
    bad_imm   = 1'b0;
    bad_group = (req.group > 3'd4);
    word[31:29] = req.group;
    word[28]    = req.op_type;
    word[27:24] = req.ra;
    case (req.group)
      3'd0, 3'd2, 3'd3: begin
        word[23:20] = req.rb;
        word[19:16] = req.rc;
        word[15:12] = req.oper;
        word[11:0]  = req.imm[11:0];
        bad_imm     = !sext_ok(req.imm, 12);
        if (req.group == 3'd0) bad_oper = (req.oper >= 4'hD);
        else                   bad_oper = req.oper[3] && (req.oper != 4'h8);
      end
      3'd1: begin
        word[23:20] = req.oper;
        word[19:0]  = req.imm[19:0];
        bad_imm     = !sext_ok(req.imm, 20);
        bad_oper    = req.oper[3] && req.oper[2];
      end
      3'd4: begin
        word[23:20] = req.rb;
        word[19:16] = req.oper;
        word[15:0]  = req.imm[15:0];
        bad_imm     = !sext_ok(req.imm, 16);
        bad_oper    = req.oper[3] && (req.oper != 4'h8);
      end
      default: ;
    endcase
  end

  // Priority: group, then oper, then immediate range.
  always_comb begin
    code = 2'd0;
    if (bad_group)     code = E_GROUP;
    else if (bad_oper) code = E_OPER;
    else if (bad_imm)  code = E_IMM;
  end

  assign legal = (code == 2'd0);

  // ---------------- handshake ----------------
  assign bus.out_valid = (state == S_NONEMPTY);
  assign pop           = bus.out_valid && bus.out_ready;
  // A full queue can still take a word when the head leaves the same cycle.
  assign bus.in_ready  = (count < DEPTH_C) || pop;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && legal;
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : 32'h0;

  // ---------------- control FSM ----------------
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
    state_nxt = (count_nxt == '0) ? S_EMPTY : S_NONEMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: out_instr is masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= word;
  end

  // ---------------- error reporting ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_valid <= accept && !legal;
      if (accept && !legal) err_code <= code;
    end
  end

`ifdef SNOW64_INSTR_ENCODER_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (accept && !legal && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_snow64_instr_encoder.sv
module tb_snow64_instr_encoder;
  localparam int DEPTH = 4;
  localparam int WIDTH_IMM = 64;

  logic clk = 1'b0;
  logic rst;
  logic err_valid;
  logic [1:0] err_code;
  logic [$clog2(DEPTH):0] count;
`ifdef SNOW64_INSTR_ENCODER_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  snow64_instr_encoder_if #(.WIDTH_IMM(WIDTH_IMM)) bus ();

  snow64_instr_encoder #(.DEPTH(DEPTH), .WIDTH_IMM(WIDTH_IMM)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_valid (err_valid),
    .err_code  (err_code),
`ifdef SNOW64_INSTR_ENCODER_ERR_COUNT_EN
    .err_count (err_count),
`endif
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] g, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rc,
                         input logic [3:0] oper, input logic [63:0] imm);
    bus.in_group   = g;
    bus.in_op_type = 1'b0;
    bus.in_ra      = ra;
    bus.in_rb      = rb;
    bus.in_rc      = rc;
    bus.in_oper    = oper;
    bus.in_imm     = imm;
  endtask

  // One-cycle request; returns 1 after the accepting edge.
  task automatic send(input logic [2:0] g, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] rc,
                      input logic [3:0] oper, input logic [63:0] imm);
    set_req(g, ra, rb, rc, oper, imm);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_req(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'h0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // group 0 basic
    send(3'd0, 4'd1, 4'd2, 4'd3, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("g0_valid", 64'(bus.out_valid), 64'd1);
    chk("g0_instr", 64'(bus.out_instr), 64'h01230FFF);
    chk("g0_count", 64'(count), 64'd1);
    pop_one();
    chk("g0_pop_count", 64'(count), 64'd0);
    chk("g0_pop_instr", 64'(bus.out_instr), 64'h0);

    // group 1, edge of simm20, then one past it
    send(3'd1, 4'd5, 4'd0, 4'd0, 4'd2, 64'h7FFFF);
    chk("g1_instr", 64'(bus.out_instr), 64'h2527FFFF);
    send(3'd1, 4'd5, 4'd0, 4'd0, 4'd2, 64'h80000);
    chk("g1_imm_errv", 64'(err_valid), 64'd1);
    chk("g1_imm_code", 64'(err_code), 64'd2);
    chk("g1_imm_count", 64'(count), 64'd1);
    @(posedge clk); #1;
    chk("errv_pulse", 64'(err_valid), 64'd0);
    chk("errcode_hold", 64'(err_code), 64'd2);
    pop_one();

    // priority and oper rules
    send(3'd5, 4'd0, 4'd0, 4'd0, 4'hF, 64'h12345);
    chk("grp_prio_code", 64'(err_code), 64'd1);
    send(3'd2, 4'd0, 4'd0, 4'd0, 4'h9, 64'd0);
    chk("g2_oper9_code", 64'(err_code), 64'd3);
    send(3'd0, 4'd0, 4'd0, 4'd0, 4'hD, 64'h800);
    chk("g0_operD_prio", 64'(err_code), 64'd3);
    send(3'd1, 4'd0, 4'd0, 4'd0, 4'hC, 64'd0);
    chk("g1_operC_code", 64'(err_code), 64'd3);
    send(3'd3, 4'd0, 4'd0, 4'd0, 4'd1, 64'h800);
    chk("g3_imm_code", 64'(err_code), 64'd2);
    send(3'd4, 4'd0, 4'd0, 4'd0, 4'd1, 64'h8000);
    chk("g4_imm_code", 64'(err_code), 64'd2);
    chk("rej_count", 64'(count), 64'd0);
    send(3'd2, 4'd0, 4'd0, 4'd0, 4'h8, 64'd0);
    chk("g2_oper8_instr", 64'(bus.out_instr), 64'h40008000);
    chk("g2_oper8_count", 64'(count), 64'd1);
    pop_one();
    send(3'd4, 4'd1, 4'd2, 4'd0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("g4_instr", 64'(bus.out_instr), 64'h8123FFFE);
    pop_one();

    // fill, then push+pop while full
    for (int k = 1; k <= DEPTH; k++)
      send(3'd4, 4'd1, 4'd2, 4'd0, 4'd3, 64'(k));
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    set_req(3'd4, 4'd1, 4'd2, 4'd0, 4'd3, 64'd5);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 64'(bus.in_ready), 64'd1);
    chk("full_head", 64'(bus.out_instr), 64'h81230001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pushpop_count", 64'(count), 64'(DEPTH));
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("order_%0d", k), 64'(bus.out_instr), 64'h81230000 | 64'(k));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // reset mid-stream
    for (int k = 1; k <= 3; k++)
      send(3'd0, 4'd0, 4'd0, 4'd0, 4'd1, 64'(k));
    chk("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_code", 64'(err_code), 64'd0);
    send(3'd0, 4'd7, 4'd0, 4'd0, 4'd2, 64'h7FF);
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_instr", 64'(bus.out_instr), 64'h070027FF);
    pop_one();
    chk("post_rst_empty", 64'(bus.out_valid), 64'd0);

`ifdef SNOW64_INSTR_ENCODER_ERR_COUNT_EN
    for (int k = 0; k < 3; k++)
      send(3'd6, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
    chk("err_count3", 64'(err_count), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
